// File: rtl/strike_prog_loader.sv
// -----------------------------------------------------------------------------
// strike_prog_loader
//   Program-memory stage for the strike CPU. A framed program image arrives as a
//   byte stream (HEADER, LEN, LEN data bytes, CHK). The loader writes the image
//   into a 2^AW x DW RAM and holds the CPU in reset until a frame with a correct
//   checksum has been received. The CPU fetches through a registered ROM-style
//   port with one cycle of latency.
//
// Ports
//   clock      in   1   single clock, all logic on posedge
//   reset      in   1   synchronous active-high reset
//   rx_data    in   DW  stream byte
//   rx_valid   in   1   rx_data valid
//   rx_ready   out  1   byte accepted when rx_valid && rx_ready
//   addr       in   AW  CPU fetch address
//   data       out  DW  mem[addr], registered
//   cpu_reset  out  1   1 = hold CPU in reset
//   loaded     out  1   1 = valid image present, CPU released
//   busy       out  1   1 = frame in progress
//   load_err   out  1   one-cycle pulse on a frame error or timeout
// -----------------------------------------------------------------------------
module strike_prog_loader #(
    parameter int            AW      = 6,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] HEADER  = 8'h5A,
    parameter int            TIMEOUT = 100000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          cpu_reset,
    output logic          loaded,
    output logic          busy,
    output logic          load_err
);

    localparam int DEPTH    = 1 << AW;
    localparam int CW       = AW + 1;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_SUM  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_rx_ready;
    logic          r_cpu_reset;
    logic          r_loaded;
    logic          r_busy;
    logic          r_load_err;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wptr;
    logic [DW-1:0] r_sum;
    logic [TW-1:0] r_tmo;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_acc;
    logic          w_busy_st;
    logic          w_len_bad;
    logic          w_tmo;
    logic          w_err;
    logic          w_wr_en;

    assign w_acc     = rx_valid && r_rx_ready;
    assign w_busy_st = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_SUM);
    // LEN of zero or beyond the RAM depth is rejected; wider compare handles AW >= DW.
    assign w_len_bad = (rx_data == {DW{1'b0}}) || (32'(rx_data) > 32'(DEPTH));
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign w_tmo     = (TIMEOUT != 0) && w_busy_st && !w_acc && (r_tmo == TW'(TMO_LAST));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: advances only on an accepted byte or on timeout
    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = S_IDLE;
        end else if (w_acc) begin
            case (r_state)
                S_IDLE:  w_next = (rx_data == HEADER) ? S_LEN : S_IDLE;
                S_LEN:   w_next = w_len_bad ? S_IDLE : S_DATA;
                S_DATA:  w_next = (r_cnt == CW'(1)) ? S_SUM : S_DATA;
                S_SUM:   w_next = (rx_data == r_sum) ? S_DONE : S_IDLE;
                S_DONE:  w_next = (rx_data == HEADER) ? S_LEN : S_DONE;
                default: w_next = S_IDLE;
            endcase
        end else begin
            w_next = r_state;
        end
    end

    // Output decode: error strobe and RAM write enable
    always_comb begin
        w_err   = 1'b0;
        w_wr_en = 1'b0;
        if (w_tmo) begin
            w_err = 1'b1;
        end else if (w_acc && !reset) begin
            case (r_state)
                S_LEN:   w_err   = w_len_bad;
                S_DATA:  w_wr_en = 1'b1;
                S_SUM:   w_err   = (rx_data != r_sum);
                default: w_err   = 1'b0;
            endcase
        end else begin
            w_err = 1'b0;
        end
    end

    // Registered status outputs, derived from the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_loaded    <= 1'b0;
            r_busy      <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_rx_ready  <= 1'b1;
            r_cpu_reset <= (w_next != S_DONE);
            r_loaded    <= (w_next == S_DONE);
            r_busy      <= (w_next == S_LEN) || (w_next == S_DATA) || (w_next == S_SUM);
            r_load_err  <= w_err;
        end
    end

    // Frame datapath: byte counter, write pointer, running checksum, idle timer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= {CW{1'b0}};
            r_wptr <= {AW{1'b0}};
            r_sum  <= {DW{1'b0}};
            r_tmo  <= {TW{1'b0}};
        end else begin
            if (w_acc && (r_state == S_LEN)) begin
                r_cnt  <= CW'(rx_data);
                r_wptr <= {AW{1'b0}};
                r_sum  <= {DW{1'b0}};
            end else if (w_wr_en) begin
                r_cnt  <= r_cnt - CW'(1);
                r_wptr <= r_wptr + AW'(1);
                r_sum  <= r_sum + rx_data;
            end
            if (w_acc || !w_busy_st || w_tmo) begin
                r_tmo <= {TW{1'b0}};
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    // Program RAM write port; contents are deliberately not reset
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    // Fetch port: read-before-write, so a same-address write returns old data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data <= {DW{1'b0}};
        end else begin
            r_data <= r_mem[addr];
        end
    end

    assign rx_ready  = r_rx_ready;
    assign data      = r_data;
    assign cpu_reset = r_cpu_reset;
    assign loaded    = r_loaded;
    assign busy      = r_busy;
    assign load_err  = r_load_err;

endmodule
